// File: rtl/axis_pkt_pkg.sv
// Shared types, default parameters and pointer-width helper for the AXI-Stream packet FIFO.
package axis_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } wr_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 64;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_pkt_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered read. The read register
// doubles as the FIFO output register, so only it is reset.
module axis_pkt_fifo_ram #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage array write port (no reset on the array).
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= wdata;
  end

  // Registered read; holds its value whenever no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata_q <= '0;
    else if (rd_en) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream packet FIFO with optional store-and-forward, oversize-packet drop
// and output/drop packet counters.
module axis_pkt_fifo
  import axis_pkt_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int DEST_W    = 1,
  parameter int ID_W      = 1,
  parameter int STORE_FWD = 1
) (
  input  logic                  aclk_0,
  input  logic                  aresetn_0,
  input  logic [DATA_W-1:0]     S_AXIS_0_tdata,
  input  logic [DATA_W/8-1:0]   S_AXIS_0_tstrb,
  input  logic                  S_AXIS_0_tlast,
  input  logic [DEST_W-1:0]     S_AXIS_0_tdest,
  input  logic [ID_W-1:0]       S_AXIS_0_tid,
  input  logic                  S_AXIS_0_tvalid,
  output logic                  S_AXIS_0_tready,
  output logic [DATA_W-1:0]     M_AXIS_0_tdata,
  output logic [DATA_W/8-1:0]   M_AXIS_0_tstrb,
  output logic                  M_AXIS_0_tlast,
  output logic [DEST_W-1:0]     M_AXIS_0_tdest,
  output logic [ID_W-1:0]       M_AXIS_0_tid,
  output logic                  M_AXIS_0_tvalid,
  input  logic                  M_AXIS_0_tready,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [15:0]           pkt_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam int SW = DATA_W / 8;
  localparam int EW = DATA_W + SW + 1 + DEST_W + ID_W;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [PW-1:0] wptr_q, wptr_d, cptr_q, cptr_d, rptr_q, rptr_d, raddr_q, raddr_d;
  logic [PW-1:0] eptr, used_d;
  wr_state_e     state_q, state_d;
  logic          full_q, full_d, rdy_q, vld_q, vld_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;
  logic          s_acc, wr_en, rd_en, m_fire, drop_hit;
  logic [EW-1:0] wr_entry, rd_entry;

  // rdy_q keeps tready low until the first edge after reset release.
  assign S_AXIS_0_tready = rdy_q && (!full_q || state_q == DROP);
  assign s_acc    = S_AXIS_0_tvalid && S_AXIS_0_tready;
  assign wr_en    = s_acc && (state_q != DROP);
  assign wr_entry = {S_AXIS_0_tdata, S_AXIS_0_tstrb, S_AXIS_0_tlast, S_AXIS_0_tdest, S_AXIS_0_tid};
  // An uncommitted packet filling the whole FIFO can never be forwarded.
  assign drop_hit = (STORE_FWD != 0) && full_q && (cptr_q == rptr_q);

  // Write-side FSM: pointer advance, commit on tlast, rollback and discard on oversize.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    cptr_d     = cptr_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      IDLE, WRITE: begin
        if (drop_hit) begin
          state_d = DROP;
          wptr_d  = cptr_q;
        end else if (wr_en) begin
          wptr_d = wptr_q + PW'(1);
          if (S_AXIS_0_tlast) begin
            cptr_d  = wptr_q + PW'(1);
            state_d = IDLE;
          end else begin
            state_d = WRITE;
          end
        end
      end
      DROP: begin
        if (s_acc && S_AXIS_0_tlast) begin
          state_d = IDLE;
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read side: prefetch into the output register whenever it is empty or being consumed.
  always_comb begin
    eptr      = (STORE_FWD != 0) ? cptr_q : wptr_q;
    m_fire    = vld_q && M_AXIS_0_tready;
    rd_en     = (eptr != raddr_q) && (!vld_q || M_AXIS_0_tready);
    raddr_d   = raddr_q + PW'(rd_en);
    vld_d     = rd_en || (vld_q && !M_AXIS_0_tready);
    rptr_d    = rptr_q + PW'(m_fire);
    pkt_cnt_d = pkt_cnt_q + 16'(m_fire && M_AXIS_0_tlast);
    used_d    = wptr_d - rptr_d;
    full_d    = (used_d == DEPTH_P);
  end

  // State, pointer, flag and counter registers.
  always_ff @(posedge aclk_0 or negedge aresetn_0) begin
    if (!aresetn_0) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      cptr_q     <= '0;
      rptr_q     <= '0;
      raddr_q    <= '0;
      full_q     <= 1'b0;
      rdy_q      <= 1'b0;
      vld_q      <= 1'b0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      cptr_q     <= cptr_d;
      rptr_q     <= rptr_d;
      raddr_q    <= raddr_d;
      full_q     <= full_d;
      rdy_q      <= 1'b1;
      vld_q      <= vld_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  axis_pkt_fifo_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (aclk_0),
    .rst_n (aresetn_0),
    .wr_en (wr_en),
    .waddr (wptr_q[AW-1:0]),
    .wdata (wr_entry),
    .rd_en (rd_en),
    .raddr (raddr_q[AW-1:0]),
    .rdata (rd_entry)
  );

  assign {M_AXIS_0_tdata, M_AXIS_0_tstrb, M_AXIS_0_tlast, M_AXIS_0_tdest, M_AXIS_0_tid} = rd_entry;
  assign M_AXIS_0_tvalid = vld_q;
  assign occupancy       = wptr_q - rptr_q;
  assign pkt_cnt         = pkt_cnt_q;
  assign drop_cnt        = drop_cnt_q;

endmodule
